// File: rtl/vga_draw_scheduler_pkg.sv
// vga_draw_pkg: shared definitions for the VGA draw scheduler.
//   SCREEN_W / SCREEN_H : visible DE1 VGA adapter resolution (160x120).
//   colour constants    : 3-bit RGB values for the adapter.
//   draw_state_t        : scheduler FSM states.
package vga_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } draw_state_t;

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// vga_draw_scheduler_if: requester bus plus VGA pixel-write port.
//   req/req_x/req_y/req_w/req_h/req_color : requester -> scheduler, packed
//                                            per requester k at [k*W +: W]
//   grant/done                             : scheduler -> requesters
//   VGA_X/VGA_Y/VGA_COLOR/plot             : scheduler -> VGA adapter
// Modports: slave = scheduler side, master = requester / adapter side.
interface vga_draw_scheduler_if #(
  parameter int NREQ = 4,
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int C_W  = 3
);
  logic [NREQ-1:0]     req;
  logic [NREQ*X_W-1:0] req_x;
  logic [NREQ*Y_W-1:0] req_y;
  logic [NREQ*X_W-1:0] req_w;
  logic [NREQ*Y_W-1:0] req_h;
  logic [NREQ*C_W-1:0] req_color;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic [X_W-1:0]      VGA_X;
  logic [Y_W-1:0]      VGA_Y;
  logic [C_W-1:0]      VGA_COLOR;
  logic                plot;

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_color,
    output grant, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );

  modport master (
    output req, req_x, req_y, req_w, req_h, req_color,
    input  grant, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );
endinterface

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter.
//   clock, resetn : clock, async active-low reset
//   i_req         : request vector
//   i_upd         : strobe; moves the priority pointer past the current winner
//   o_gnt / o_idx : one-hot winner and its index (combinational)
//   o_vld         : any request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_upd,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_vld
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_k;
  int            w_sum;

  // Scan from the pointer upward, wrapping; the first set request wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_sum = 0;
    w_k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_k = PW'(w_sum);
      if (!o_vld && i_req[w_k]) begin
        o_vld      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_upd && o_vld) begin
      r_ptr <= (o_idx == PW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: shares the single VGA pixel-write port between the
// rectangle requesters (clear, paddle, ball, brick). Grants round-robin and
// rasters the winner's solid rectangle one pixel per clock, then pulses done.
//   clock, resetn : system clock, async active-low reset
//   bus (slave)   : requester bus and VGA port (vga_draw_scheduler_if)
//   busy          : high in DRAW and DONE
// Optional build macro VGA_SCHED_CLIP_EN: suppresses plot for pixels outside
// the 160x120 screen (coordinate carry included); otherwise coordinates wrap.
module vga_draw_scheduler
  import vga_draw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int C_W  = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  vga_draw_scheduler_if.slave   bus,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  draw_state_t r_state, w_next;

  logic [NREQ-1:0] w_arb_gnt;
  logic [PW-1:0]   w_arb_idx;
  logic            w_arb_vld;
  logic            w_grant_edge;

  logic [NREQ-1:0] r_gnt;
  logic [X_W-1:0]  r_x0, r_w, r_cx;
  logic [Y_W-1:0]  r_y0, r_h, r_cy;
  logic [C_W-1:0]  r_color;

  logic [NREQ-1:0][X_W-1:0] w_rx, w_rw;
  logic [NREQ-1:0][Y_W-1:0] w_ry, w_rh;
  logic [NREQ-1:0][C_W-1:0] w_rc;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_rx[k] = bus.req_x[k*X_W +: X_W];
    assign w_rw[k] = bus.req_w[k*X_W +: X_W];
    assign w_ry[k] = bus.req_y[k*Y_W +: Y_W];
    assign w_rh[k] = bus.req_h[k*Y_W +: Y_W];
    assign w_rc[k] = bus.req_color[k*C_W +: C_W];
  end

  logic [X_W-1:0] w_sx, w_sw;
  logic [Y_W-1:0] w_sy, w_sh;
  logic [C_W-1:0] w_sc;
  logic           w_zero, w_last, w_on;

  assign w_sx   = w_rx[w_arb_idx];
  assign w_sw   = w_rw[w_arb_idx];
  assign w_sy   = w_ry[w_arb_idx];
  assign w_sh   = w_rh[w_arb_idx];
  assign w_sc   = w_rc[w_arb_idx];
  assign w_zero = (w_sw == '0) || (w_sh == '0);
  assign w_last = (r_cx == r_w - 1'b1) && (r_cy == r_h - 1'b1);

  // The pointer moves at grant time; nothing arbitrates during a service,
  // so this is equivalent to moving it when the service completes.
  assign w_grant_edge = (r_state == ST_IDLE) && w_arb_vld;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .clock  (clock),
    .resetn (resetn),
    .i_req  (bus.req),
    .i_upd  (w_grant_edge),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx),
    .o_vld  (w_arb_vld)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_arb_vld) w_next = w_zero ? ST_DONE : ST_DRAW;
      ST_DRAW: if (w_last)    w_next = ST_DONE;
      ST_DONE:                w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Rectangle latch and raster counters. Origin, colour and counters are
  // only reloaded when a real draw starts, so the pixel outputs keep their
  // last values through DONE, IDLE and zero-size services. At the final
  // pixel the counters hold instead of wrapping for the same reason.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_gnt   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_color <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_arb_vld) begin
          r_gnt <= w_arb_gnt;
          r_w   <= w_sw;
          r_h   <= w_sh;
          if (!w_zero) begin
            r_x0    <= w_sx;
            r_y0    <= w_sy;
            r_color <= w_sc;
            r_cx    <= '0;
            r_cy    <= '0;
          end
        end
        ST_DRAW: begin
          if (r_cx == r_w - 1'b1) begin
            if (r_cy != r_h - 1'b1) begin
              r_cx <= '0;
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        ST_DONE: r_gnt <= '0;
        default: ;
      endcase
    end
  end

`ifdef VGA_SCHED_CLIP_EN
  // One extra bit keeps the carry; any carry is >= 2^X_W and therefore
  // already fails the screen-bound compare.
  logic [X_W:0] w_px;
  logic [Y_W:0] w_py;
  assign w_px      = {1'b0, r_x0} + {1'b0, r_cx};
  assign w_py      = {1'b0, r_y0} + {1'b0, r_cy};
  assign w_on      = (w_px < (X_W+1)'(SCREEN_W)) && (w_py < (Y_W+1)'(SCREEN_H));
  assign bus.VGA_X = w_px[X_W-1:0];
  assign bus.VGA_Y = w_py[Y_W-1:0];
`else
  assign w_on      = 1'b1;
  assign bus.VGA_X = r_x0 + r_cx;
  assign bus.VGA_Y = r_y0 + r_cy;
`endif

  assign bus.VGA_COLOR = r_color;

  // Outputs
  always_comb begin
    busy      = (r_state != ST_IDLE);
    bus.grant = r_gnt;
    bus.done  = (r_state == ST_DONE) ? r_gnt : '0;
    bus.plot  = (r_state == ST_DRAW) && w_on;
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
module tb_vga_draw_scheduler;
  localparam int NREQ = 4, X_W = 8, Y_W = 7, C_W = 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic busy;

  vga_draw_scheduler_if #(.NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus();

  vga_draw_scheduler #(.NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  typedef struct { int id; int w; int h; bit b2b; } svc_t;
  typedef struct { int x; int y; int c; } pix_t;

  svc_t svc_q[$];
  pix_t pix_q[$];
  int total = 0, bad = 0;
  int cyc = 0, pix_seen = 0, model_ptr = 0;
  int rx[NREQ], ry[NREQ], rw[NREQ], rh[NREQ], rc[NREQ];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"}, int'(bus.grant), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_plot"},  int'(bus.plot), 0);
    chk({tag, "_vx"},    int'(bus.VGA_X), 0);
    chk({tag, "_vy"},    int'(bus.VGA_Y), 0);
    chk({tag, "_vc"},    int'(bus.VGA_COLOR), 0);
  endtask

  task automatic set_req(int k, int x, int y, int w, int h, int c);
    rx[k] = x; ry[k] = y; rw[k] = w; rh[k] = h; rc[k] = c;
    bus.req_x[k*X_W +: X_W]     = X_W'(x);
    bus.req_y[k*Y_W +: Y_W]     = Y_W'(y);
    bus.req_w[k*X_W +: X_W]     = X_W'(w);
    bus.req_h[k*Y_W +: Y_W]     = Y_W'(h);
    bus.req_color[k*C_W +: C_W] = C_W'(c);
  endtask

  // Reference: a service of g emits every pixel of the rectangle in raster
  // order; off-screen pixels are dropped (clip) or wrap (no clip).
  task automatic serve(int g, bit b2b);
    svc_t s;
    pix_t p;
    s.id = g; s.w = rw[g]; s.h = rh[g]; s.b2b = b2b;
    svc_q.push_back(s);
    for (int j = 0; j < rh[g]; j++)
      for (int i = 0; i < rw[g]; i++) begin
        p.x = rx[g] + i; p.y = ry[g] + j; p.c = rc[g];
`ifdef VGA_SCHED_CLIP_EN
        if (p.x < 160 && p.y < 120) pix_q.push_back(p);
`else
        p.x = p.x % 256; p.y = p.y % 128;
        pix_q.push_back(p);
`endif
      end
    model_ptr = (g + 1) % NREQ;
  endtask

  // Requests raised together and held are served in round-robin order.
  task automatic arbitrate(int mask);
    bit first;
    int m;
    first = 1'b1;
    m = mask;
    while (m != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (model_ptr + i) % NREQ;
        if (m[k]) begin
          serve(k, !first);
          m[k] = 1'b0;
          first = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic raise(int mask);
    @(negedge clock);
    bus.req = bus.req | NREQ'(mask);
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((svc_q.size() != 0 || bus.req != 0 || busy) && n < budget);
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL idle_timeout after %0d cycles, pending services=%0d required 0", n, svc_q.size());
    end
    repeat (2) @(negedge clock);
  endtask

  // Requesters: drop req in the done cycle; scramble rectangle fields while
  // being served (they only need to be valid on the granting edge).
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < NREQ; k++) begin
        if (resetn && bus.done[k]) bus.req[k] = 1'b0;
        else if (resetn && bus.grant[k]) begin
          bus.req_x[k*X_W +: X_W]     = X_W'($urandom);
          bus.req_y[k*Y_W +: Y_W]     = Y_W'($urandom);
          bus.req_w[k*X_W +: X_W]     = X_W'($urandom);
          bus.req_h[k*Y_W +: Y_W]     = Y_W'($urandom);
          bus.req_color[k*C_W +: C_W] = C_W'($urandom);
        end
      end
    end
  end

  // Monitor / scoreboard
  svc_t mon_cur;
  pix_t mon_p;
  bit   mon_in = 1'b0;
  bit   mon_gbad;
  int   mon_bcnt, mon_last_done = -100;
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        mon_in = 1'b0;
      end else begin
        if (!mon_in && bus.grant != 0) begin
          if (svc_q.size() == 0) chk("grant_unexpected", int'(bus.grant), 0);
          else begin
            mon_cur = svc_q.pop_front();
            mon_in = 1'b1; mon_bcnt = 0; mon_gbad = 1'b0;
            chk("grant_id", int'(bus.grant), 1 << mon_cur.id);
            if (mon_cur.b2b) chk("b2b_gap", cyc - mon_last_done, 2);
          end
        end
        if (bus.plot) begin
          if (pix_q.size() == 0) chk("plot_unexpected", int'(bus.plot), 0);
          else begin
            mon_p = pix_q.pop_front();
            chk("pix_x", int'(bus.VGA_X), mon_p.x);
            chk("pix_y", int'(bus.VGA_Y), mon_p.y);
            chk("pix_c", int'(bus.VGA_COLOR), mon_p.c);
          end
          pix_seen++;
        end
        if (mon_in) begin
          if (busy) mon_bcnt++;
          if (bus.grant != NREQ'(1 << mon_cur.id)) mon_gbad = 1'b1;
          if (bus.done != 0) begin
            chk("done_id", int'(bus.done), 1 << mon_cur.id);
            chk("busy_cycles", mon_bcnt, mon_cur.w * mon_cur.h + 1);
            chk("grant_held", int'(mon_gbad), 0);
            mon_last_done = cyc;
            mon_in = 1'b0;
          end
        end else if (bus.done != 0) begin
          chk("done_stray", int'(bus.done), 0);
        end
      end
    end
  end

  initial begin
    int base, n, mask;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0;
    bus.req_w = '0; bus.req_h = '0; bus.req_color = '0;
    #1;
    chk_zero("por");
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    // Reset in the middle of a 10x10 rectangle
    set_req(2, 20, 20, 10, 10, 5);
    arbitrate(4'b0100);
    raise(4'b0100);
    base = pix_seen; n = 0;
    while (pix_seen - base < 37 && n < 500) begin @(negedge clock); n++; end
    #2 resetn = 1'b0;
    #1 chk_zero("midrst");
    bus.req = '0;
    svc_q.delete(); pix_q.delete(); model_ptr = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    // pointer back at 0: requester 1 must beat requester 3
    set_req(1, 40, 30, 2, 3, 6);
    set_req(3, 70, 60, 3, 1, 1);
    arbitrate(4'b1010);
    raise(4'b1010);
    wait_idle(200);

    // All four with 1x1, requester 0 asks again during the round
    for (int k = 0; k < NREQ; k++) set_req(k, 10 * k, 5 * k, 1, 1, k + 1);
    arbitrate(4'b1111);
    raise(4'b1111);
    n = 0;
    while (!bus.done[0] && n < 100) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    set_req(0, 99, 88, 1, 1, 7);
    serve(0, 1'b1);
    bus.req[0] = 1'b1;
    wait_idle(200);

    // Single 3x2 rectangle
    set_req(2, 5, 7, 3, 2, 3'b100);
    arbitrate(4'b0100);
    raise(4'b0100);
    wait_idle(100);

    // Zero width
    set_req(1, 10, 10, 0, 4, 7);
    arbitrate(4'b0010);
    raise(4'b0010);
    wait_idle(100);

    // Screen edge
    set_req(1, 158, 119, 4, 2, 2);
    arbitrate(4'b0010);
    raise(4'b0010);
    wait_idle(100);

    // Full clear with a brick request arriving mid-clear
    set_req(0, 0, 0, 160, 120, 0);
    arbitrate(4'b0001);
    raise(4'b0001);
    base = pix_seen; n = 0;
    while (pix_seen - base < 500 && n < 2000) begin @(negedge clock); n++; end
    set_req(3, 150, 115, 12, 7, 6);
    serve(3, 1'b1);
    bus.req[3] = 1'b1;
    wait_idle(25000);

    // Random rounds
    for (int r = 0; r < 25; r++) begin
      mask = int'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++)
        if (mask[k]) set_req(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                             int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                             int'($urandom_range(0, 7)));
      arbitrate(mask);
      raise(mask);
      wait_idle(2000);
    end

    chk("pix_left", pix_q.size(), 0);
    chk("svc_left", svc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
